// File: rtl/orion_types.sv
// Core-wide architectural widths shared by the decode/writeback path.
package orion_types;
    parameter int XLEN        = 32;
    parameter int RF_IDX_BITS = 5;
    parameter int NUM_REGS    = 32;
endpackage

// File: rtl/regfile_sb.sv
// Multi-port integer register file with same-cycle write forwarding and an
// integrated busy-bit scoreboard for RAW hazard detection at decode.
module regfile_sb
    import orion_types::*;
#(
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 1,
    parameter int CNT_BITS     = $clog2(NUM_REGS + 1)
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [NUM_RD_PORTS-1:0][RF_IDX_BITS-1:0]  rs_s_i,
    output logic [NUM_RD_PORTS-1:0][XLEN-1:0]         rs_v_o,
    output logic [NUM_RD_PORTS-1:0]                   rs_rdy_o,
    input  logic [NUM_WR_PORTS-1:0]                   we_i,
    input  logic [NUM_WR_PORTS-1:0][RF_IDX_BITS-1:0]  rd_s_i,
    input  logic [NUM_WR_PORTS-1:0][XLEN-1:0]         rd_v_i,
    input  logic                                      alloc_i,
    input  logic [RF_IDX_BITS-1:0]                    alloc_rd_i,
    input  logic                                      flush_i,
    output logic [CNT_BITS-1:0]                       busy_cnt_o
);

    logic [XLEN-1:0]     regs_q [NUM_REGS];
    logic [XLEN-1:0]     regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [CNT_BITS-1:0] busy_cnt;

    // Ascending port order lets the highest-numbered writer win.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
            if (we_i[w] && (rd_s_i[w] != '0)) begin
                regs_d[rd_s_i[w]] = rd_v_i[w];
            end
        end
        regs_d[0] = '0;
    end

    // Writeback clears, alloc overrides a same-cycle writeback, flush clears all.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
            if (we_i[w]) begin
                busy_d[rd_s_i[w]] = 1'b0;
            end
        end
        if (alloc_i) begin
            busy_d[alloc_rd_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rs_v_o   = '0;
        rs_rdy_o = '1;
        for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
            if (rs_s_i[p] != '0) begin
                rs_v_o[p]   = regs_q[rs_s_i[p]];
                rs_rdy_o[p] = !busy_q[rs_s_i[p]];
                for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
                    if (we_i[w] && (rd_s_i[w] == rs_s_i[p])) begin
                        rs_v_o[p]   = rd_v_i[w];
                        rs_rdy_o[p] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        busy_cnt = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            busy_cnt = busy_cnt + CNT_BITS'(busy_q[r]);
        end
    end

    assign busy_cnt_o = busy_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised bench for regfile_sb against an array-based reference model,
// preceded by directed scenarios with literal expectations.
module tb_regfile_sb;
    import orion_types::*;

    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int CB  = $clog2(NUM_REGS + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                            rst;
    logic [NRD-1:0][RF_IDX_BITS-1:0] rs_s;
    logic [NRD-1:0][XLEN-1:0]        rs_v;
    logic [NRD-1:0]                  rs_rdy;
    logic [NWR-1:0]                  we;
    logic [NWR-1:0][RF_IDX_BITS-1:0] rd_s;
    logic [NWR-1:0][XLEN-1:0]        rd_v;
    logic                            alloc;
    logic [RF_IDX_BITS-1:0]          alloc_rd;
    logic                            flush;
    logic [CB-1:0]                   busy_cnt;

    regfile_sb #(
        .NUM_RD_PORTS (NRD),
        .NUM_WR_PORTS (NWR),
        .CNT_BITS     (CB)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rs_s_i     (rs_s),
        .rs_v_o     (rs_v),
        .rs_rdy_o   (rs_rdy),
        .we_i       (we),
        .rd_s_i     (rd_s),
        .rd_v_i     (rd_v),
        .alloc_i    (alloc),
        .alloc_rd_i (alloc_rd),
        .flush_i    (flush),
        .busy_cnt_o (busy_cnt)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state as plain arrays.
    logic [XLEN-1:0] m_regs [NUM_REGS];
    bit              m_busy [NUM_REGS];
    bit              m_valid = 1'b0;

    always @(negedge clk) begin
        if (m_valid) begin
            int exp_cnt;
            for (int p = 0; p < NRD; p++) begin
                int              r;
                int              hit;
                logic [XLEN-1:0] ev;
                bit              er;
                r   = int'(rs_s[p]);
                hit = -1;
                for (int w = 0; w < NWR; w++)
                    if (we[w] && int'(rd_s[w]) == r) hit = w;
                if (r == 0) begin
                    ev = '0;
                    er = 1'b1;
                end else if (hit >= 0) begin
                    ev = rd_v[hit];
                    er = 1'b1;
                end else begin
                    ev = m_regs[r];
                    er = !m_busy[r];
                end
                chk($sformatf("model rs_v[%0d] x%0d", p, r), rs_v[p], ev);
                chk($sformatf("model rs_rdy[%0d] x%0d", p, r), 32'(rs_rdy[p]), 32'(er));
            end
            exp_cnt = 0;
            for (int r = 0; r < NUM_REGS; r++) exp_cnt += int'(m_busy[r]);
            chk("model busy_cnt", 32'(busy_cnt), 32'(exp_cnt));
        end
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
            m_valid = 1'b1;
        end else if (m_valid) begin
            for (int w = 0; w < NWR; w++) begin
                if (we[w] && rd_s[w] != 0) m_regs[rd_s[w]] = rd_v[w];
                if (we[w]) m_busy[rd_s[w]] = 1'b0;
            end
            if (alloc && alloc_rd != 0) m_busy[alloc_rd] = 1'b1;
            if (flush)
                for (int r = 0; r < NUM_REGS; r++) m_busy[r] = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        we    = '0;
        alloc = 1'b0;
        flush = 1'b0;
        rst   = 1'b0;
    endtask

    function automatic logic [RF_IDX_BITS-1:0] pick();
        if ($urandom_range(3) == 0) return RF_IDX_BITS'($urandom);
        return RF_IDX_BITS'($urandom_range(7));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        we       = '0;
        rd_s     = '0;
        rd_v     = '0;
        alloc    = 1'b0;
        alloc_rd = '0;
        flush    = 1'b0;
        rs_s     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        rs_s[0] = 5'd5;
        rs_s[1] = 5'd5;
        #2;
        chk("reset rs_v0", rs_v[0], 32'h0);
        chk("reset rs_v1", rs_v[1], 32'h0);
        chk("reset rdy", 32'(rs_rdy), 32'h3);
        chk("reset cnt", 32'(busy_cnt), 32'h0);

        tick(); we = 2'b01; rd_s[0] = 5'd3; rd_v[0] = 32'hDEADBEEF; rs_s[0] = 5'd3; #2;
        chk("fwd x3", rs_v[0], 32'hDEADBEEF);
        chk("fwd x3 rdy", 32'(rs_rdy[0]), 32'h1);
        tick(); quiet(); #2;
        chk("held x3", rs_v[0], 32'hDEADBEEF);

        tick(); we = 2'b11; rd_s[0] = 5'd7; rd_s[1] = 5'd7;
        rd_v[0] = 32'h11; rd_v[1] = 32'h22; rs_s[1] = 5'd7; #2;
        chk("dual wr fwd x7", rs_v[1], 32'h22);
        tick(); quiet(); #2;
        chk("dual wr held x7", rs_v[1], 32'h22);

        tick(); alloc = 1'b1; alloc_rd = 5'd9; rs_s[0] = 5'd9; #2;
        chk("alloc cycle rdy", 32'(rs_rdy[0]), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick(); quiet(); #2;
            chk("busy x9 rdy", 32'(rs_rdy[0]), 32'h0);
            chk("busy x9 cnt", 32'(busy_cnt), 32'h1);
        end
        tick(); we = 2'b01; rd_s[0] = 5'd9; rd_v[0] = 32'h55; #2;
        chk("wb x9 fwd", rs_v[0], 32'h55);
        chk("wb x9 rdy", 32'(rs_rdy[0]), 32'h1);
        chk("wb x9 cnt same cycle", 32'(busy_cnt), 32'h1);
        tick(); quiet(); #2;
        chk("wb x9 cnt after", 32'(busy_cnt), 32'h0);

        tick(); alloc = 1'b1; alloc_rd = 5'd4; we = 2'b01; rd_s[0] = 5'd4;
        rd_v[0] = 32'h99; rs_s[1] = 5'd4; #2;
        chk("alloc+wb x4 fwd", rs_v[1], 32'h99);
        tick(); quiet(); #2;
        chk("alloc+wb x4 data", rs_v[1], 32'h99);
        chk("alloc+wb x4 busy", 32'(rs_rdy[1]), 32'h0);
        chk("alloc+wb x4 cnt", 32'(busy_cnt), 32'h1);

        tick(); flush = 1'b1;
        tick(); quiet(); #2;
        chk("flush clears x4", 32'(busy_cnt), 32'h0);
        tick(); alloc = 1'b1; alloc_rd = 5'd1;
        tick(); alloc_rd = 5'd2;
        tick(); alloc_rd = 5'd3;
        tick(); quiet(); flush = 1'b1; we = 2'b01; rd_s[0] = 5'd2; rd_v[0] = 32'h7;
        rs_s[0] = 5'd2; #2;
        chk("three busy", 32'(busy_cnt), 32'h3);
        chk("flush wb x2 fwd", rs_v[0], 32'h7);
        tick(); quiet(); #2;
        chk("flush cnt 0", 32'(busy_cnt), 32'h0);
        chk("flush x2 val", rs_v[0], 32'h7);
        chk("flush x2 rdy", 32'(rs_rdy[0]), 32'h1);

        tick(); we = 2'b01; rd_s[0] = 5'd0; rd_v[0] = 32'hFFFFFFFF;
        alloc = 1'b1; alloc_rd = 5'd0; rs_s[0] = 5'd0; #2;
        chk("x0 same cycle val", rs_v[0], 32'h0);
        chk("x0 same cycle rdy", 32'(rs_rdy[0]), 32'h1);
        tick(); quiet(); #2;
        chk("x0 after val", rs_v[0], 32'h0);
        chk("x0 after rdy", 32'(rs_rdy[0]), 32'h1);
        chk("x0 after cnt", 32'(busy_cnt), 32'h0);

        for (int c = 0; c < 3000; c++) begin
            tick();
            rst      = ($urandom_range(63) == 0);
            flush    = ($urandom_range(15) == 0);
            alloc    = ($urandom_range(2) == 0);
            alloc_rd = pick();
            for (int w = 0; w < NWR; w++) begin
                we[w]   = ($urandom_range(2) == 0);
                rd_s[w] = pick();
                rd_v[w] = $urandom;
            end
            for (int p = 0; p < NRD; p++) rs_s[p] = pick();
        end
        tick();
        quiet();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port integer register file with an integrated busy-bit scoreboard. It is the next-generation register file for the core's decode/writeback path. It offers a configurable number of read and write ports, and forwards write data to reads in the same cycle. It also tracks which architectural registers have an in-flight producer, so decode can stall on RAW hazards without a separate scoreboard block. Widths come from `orion_types` (`XLEN`, `RF_IDX_BITS`, `NUM_REGS`).

## Interface
Parameters:
- `NUM_RD_PORTS`, default 2: number of read ports, at least 1.
- `NUM_WR_PORTS`, default 1: number of write (writeback) ports, at least 1.
- `CNT_BITS`, default `$clog2(NUM_REGS+1)`: width of the busy counter.

Ports:
- `clk_i`, in, 1: single clock. All state updates on the rising edge.
- `rst_i`, in, 1: synchronous, active-high reset.
- `rs_s_i`, in, `NUM_RD_PORTS`×`RF_IDX_BITS`: read-port register indices.
- `rs_v_o`, out, `NUM_RD_PORTS`×`XLEN`: read-port values.
- `rs_rdy_o`, out, `NUM_RD_PORTS`: 1 when the value on the port is architecturally valid, meaning no pending producer.
- `we_i`, in, `NUM_WR_PORTS`: write enables.
- `rd_s_i`, in, `NUM_WR_PORTS`×`RF_IDX_BITS`: write indices.
- `rd_v_i`, in, `NUM_WR_PORTS`×`XLEN`: write data.
- `alloc_i`, in, 1: an issuing instruction claims a destination.
- `alloc_rd_i`, in, `RF_IDX_BITS`: destination being claimed.
- `flush_i`, in, 1: pipeline flush. Clears all busy bits.
- `busy_cnt_o`, out, `CNT_BITS`: number of registers currently busy.

## Operation
- **Storage:** `regs[NUM_REGS]` of `XLEN` bits, plus `busy[NUM_REGS]`. Register 0 reads 0, is never written, and is never busy.
- **Write:**
  - Port w commits `rd_v_i[w]` to `regs[rd_s_i[w]]` when `we_i[w]` is set and `rd_s_i[w]` is not 0.
  - If several ports write the same index in one cycle, the highest-numbered port wins.
- **Read (combinational):** for port p with index r = `rs_s_i[p]`:
  - If r is 0: `rs_v_o[p]` is 0 and `rs_rdy_o[p]` is 1.
  - Else if any write port this cycle has `we_i` set and `rd_s_i` equal to r: `rs_v_o[p]` takes the data of the highest-numbered matching port, and `rs_rdy_o[p]` is 1. This is transparent forwarding.
  - Otherwise: `rs_v_o[p]` is `regs[r]` and `rs_rdy_o[p]` is `!busy[r]`.
- **Scoreboard next-state for busy[r], r not 0, in priority order:**
  1. `rst_i` or `flush_i`: 0.
  2. `alloc_i` set and `alloc_rd_i` equal to r: 1. A new producer overrides a same-cycle writeback to the same register.
  3. Any write port with `we_i` set and `rd_s_i` equal to r: 0.
  4. Otherwise: hold.
- **Register 0 claims:** `alloc_i` with `alloc_rd_i` equal to 0 has no effect.
- **Busy counter:** `busy_cnt_o` is the popcount of the registered `busy` vector. It changes only on clock edges and saturation is impossible.
- **Flush:** `flush_i` does not block writes in the same cycle; data is still committed.
- **Reset:** `rst_i` clears all `regs` to 0 and all `busy` to 0 in one cycle. It takes priority over every write, alloc and flush input.

## Timing
- **Read path:** zero latency. `rs_v_o` and `rs_rdy_o` are purely combinational from the indices, `we_i`/`rd_*`, and state.
- **Write to read:** a write is visible through forwarding in the same cycle, and from `regs` starting the next cycle.
- **Alloc to ready:** after `alloc_i` at edge N, reads of that register show `rs_rdy_o`=0 from cycle N+1. This lasts until a write to that register (forwarded ready in its own cycle), a flush, or a reset.
- **Counter:** `busy_cnt_o` reflects state after the most recent edge. After a single alloc it rises by 1 one cycle later.
- **Reset values:**
  - `busy_cnt_o` is 0.
  - `rs_rdy_o` is all 1s.
  - `rs_v_o` is 0 unless forwarding in the same cycle.
- **Reset mid-operation:** pending allocs and writes in the reset cycle are discarded.
- **No handshake backpressure:** the block never stalls its inputs.

## Test plan
- Reset, then read x5 on both ports → `rs_v_o`=0, `rs_rdy_o`=1 on both, `busy_cnt_o`=0.
- Write x3=0xDEADBEEF on port 0 while reading x3 in the same cycle → forwarded 0xDEADBEEF in that cycle, and the value is held from `regs` in the next cycle.
- With `NUM_WR_PORTS`=2, ports 0 and 1 both write x7 (0x11 and 0x22) → read shows 0x22 in the same cycle and afterwards.
- Alloc x9, then read x9 for 3 cycles → `rs_rdy_o`=0 and `busy_cnt_o`=1. Then write x9=0x55 → `rs_rdy_o`=1 with 0x55 in the same cycle, and `busy_cnt_o`=0 in the next cycle.
- In the same cycle, alloc x4 and write x4=0x99 → data 0x99 is stored, busy[4]=1 the next cycle, and `rs_rdy_o`=0 on a read of x4.
- Alloc x1, x2 and x3, then assert `flush_i` together with a write x2=0x7 → `busy_cnt_o` goes 3→0, x2 reads 0x7 as ready. A write to x0 or an alloc of x0 leaves x0 reading 0 and ready.
